fetch_sequencer: RTL and testbench



---
 rtl/fetch_sequencer.sv | 124 ++++++++++++
 tb/tb_fetch_sequencer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Instruction-fetch front end: owns the PC, issues one imem request at a time,
// hands fetched words to decode with valid/stall flow control, and parks on halt.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] HALT_INST = 32'h0000_000c
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_addr,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_data,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic [31:0] pc4,
    output logic        halted
);

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_VALID = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [XLEN-1:0]   r_pc;
    logic [XLEN-1:0]   r_inst;
    logic [XLEN-1:0]   r_inst_pc;
    logic [XLEN-1:0]   r_pc4;
    logic              r_imem_req;
    logic              r_inst_valid;
    logic              r_halted;

    logic [XLEN-1:0]   w_pc_next;
    logic [XLEN-1:0]   w_inst_next;
    logic [XLEN-1:0]   w_inst_pc_next;
    logic [XLEN-1:0]   w_pc4_next;
    logic [XLEN-1:0]   w_pc_plus4;
    logic [XLEN-1:0]   w_redirect_pc;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state <= S_REQ;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Redirect outranks capture, consume and halt; HALT is sticky until reset.
    always_comb begin
        w_next_state   = r_state;
        w_pc_next      = r_pc;
        w_inst_next    = r_inst;
        w_inst_pc_next = r_inst_pc;
        w_pc4_next     = r_pc4;
        w_pc_plus4     = r_pc + XLEN'(4);
        w_redirect_pc  = redirect_addr & ~XLEN'(3);

        case (r_state)
            S_REQ: begin
                if (redirect_valid) begin
                    w_pc_next = w_redirect_pc;
                end else if (imem_ready) begin
                    w_inst_next    = imem_data;
                    w_inst_pc_next = r_pc;
                    w_pc4_next     = w_pc_plus4;
                    w_pc_next      = w_pc_plus4;
                    w_next_state   = S_VALID;
                end
            end
            S_VALID: begin
                if (redirect_valid) begin
                    w_pc_next    = w_redirect_pc;
                    w_next_state = S_REQ;
                end else if (!stall) begin
                    w_next_state = (r_inst == HALT_INST) ? S_HALT : S_REQ;
                end
            end
            S_HALT: begin
                w_next_state = S_HALT;
            end
            default: begin
                w_next_state = S_REQ;
            end
        endcase
    end

    // Status outputs are registered copies of the next-state decode.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_pc         <= RESET_PC;
            r_inst       <= '0;
            r_inst_pc    <= '0;
            r_pc4        <= '0;
            r_imem_req   <= 1'b1;
            r_inst_valid <= 1'b0;
            r_halted     <= 1'b0;
        end else begin
            r_pc         <= w_pc_next;
            r_inst       <= w_inst_next;
            r_inst_pc    <= w_inst_pc_next;
            r_pc4        <= w_pc4_next;
            r_imem_req   <= (w_next_state == S_REQ);
            r_inst_valid <= (w_next_state == S_VALID);
            r_halted     <= (w_next_state == S_HALT);
        end
    end

    assign imem_req   = r_imem_req;
    assign imem_addr  = r_pc;
    assign inst_valid = r_inst_valid;
    assign inst       = r_inst;
    assign inst_pc    = r_inst_pc;
    assign pc4        = r_pc4;
    assign halted     = r_halted;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomized bench for fetch_sequencer: a transaction-level fetch model predicts
// every instruction decode should consume; a negedge monitor checks them in order.
module tb_fetch_sequencer;

    localparam logic [31:0] HALT = 32'h0000_000c;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] pc4;
    } item_t;

    logic        clk = 1'b0;
    logic        rst_b;
    logic        redirect_valid;
    logic [31:0] redirect_addr;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_data;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [31:0] pc4;
    logic        halted;

    logic        w_req;
    logic [31:0] w_addr;
    logic [31:0] w_data;
    logic        w_valid;
    logic [31:0] w_inst;
    logic [31:0] w_inst_pc;
    logic [31:0] w_pc4;
    logic        w_halted;
    logic        one  = 1'b1;
    logic        zero = 1'b0;
    logic [31:0] zero32 = 32'h0;

    logic [31:0] halt_addr = 32'h0000_0001;

    // Memory image: HALT at halt_addr only; every other word is odd, so never HALT.
    function automatic logic [31:0] mem_word(input logic [31:0] a, input logic [31:0] ha);
        if (a == ha) return HALT;
        return (a * 32'h9E37_79B1) | 32'h1;
    endfunction

    assign imem_data = mem_word(imem_addr, halt_addr);
    assign w_data    = mem_word(w_addr, halt_addr);

    always #5 clk = ~clk;

    fetch_sequencer u_dut (
        .clk(clk), .rst_b(rst_b),
        .redirect_valid(redirect_valid), .redirect_addr(redirect_addr), .stall(stall),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_data(imem_data),
        .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .pc4(pc4), .halted(halted)
    );

    fetch_sequencer #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk(clk), .rst_b(rst_b),
        .redirect_valid(zero), .redirect_addr(zero32), .stall(zero),
        .imem_req(w_req), .imem_addr(w_addr), .imem_ready(one), .imem_data(w_data),
        .inst_valid(w_valid), .inst(w_inst), .inst_pc(w_inst_pc), .pc4(w_pc4), .halted(w_halted)
    );

    int    checks   = 0;
    int    failures = 0;
    item_t exp_q[$];
    item_t mon_e;

    // Reference model: next fetch address, the word held for decode, halted flag.
    logic [31:0] m_pc;
    bit          m_hold;
    bit          m_halted;
    item_t       m_item;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, advance the model across the edge, check state after it.
    task automatic step(input logic rv, input logic [31:0] ra, input logic st, input logic rd);
        redirect_valid = rv;
        redirect_addr  = ra;
        stall          = st;
        imem_ready     = rd;
        if (!m_halted) begin
            if (rv) begin
                m_pc   = ra & ~32'h3;
                m_hold = 1'b0;
            end else if (m_hold) begin
                if (!st) begin
                    exp_q.push_back(m_item);
                    m_hold = 1'b0;
                    if (m_item.inst == HALT) m_halted = 1'b1;
                end
            end else if (rd) begin
                m_item = {mem_word(m_pc, halt_addr), m_pc, m_pc + 32'd4};
                m_hold = 1'b1;
                m_pc   = m_pc + 32'd4;
            end
        end
        @(posedge clk);
        #1;
        chk("imem_req",   32'(imem_req),   32'(!m_halted && !m_hold));
        chk("imem_addr",  imem_addr,       m_pc);
        chk("inst_valid", 32'(inst_valid), 32'(m_hold));
        chk("halted",     32'(halted),     32'(m_halted));
    endtask

    task automatic rand_step();
        logic [31:0] ra;
        ra = ($urandom % 4 == 0) ? (32'hFFFF_FFF0 | ($urandom % 16)) : $urandom;
        step(($urandom % 12) == 0, ra, ($urandom % 3) == 0, ($urandom % 2) == 1);
    endtask

    task automatic do_reset();
        rst_b          = 1'b0;
        redirect_valid = 1'b0;
        redirect_addr  = 32'h0;
        stall          = 1'b0;
        imem_ready     = 1'b0;
        #1;
        chk("rst inst_valid", 32'(inst_valid), 32'h0);
        chk("rst inst",       inst,            32'h0);
        chk("rst inst_pc",    inst_pc,         32'h0);
        chk("rst pc4",        pc4,             32'h0);
        chk("rst halted",     32'(halted),     32'h0);
        chk("rst imem_addr",  imem_addr,       32'h0);
        m_pc     = 32'h0;
        m_hold   = 1'b0;
        m_halted = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_b = 1'b1;
        chk("post-rst imem_req",  32'(imem_req), 32'h1);
        chk("post-rst imem_addr", imem_addr,     32'h0);
    endtask

    // Scoreboard monitor: a consume is inst_valid with no stall and no redirect.
    always @(negedge clk) begin
        if (rst_b && inst_valid && !stall && !redirect_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL consume: unexpected inst %h at pc %h, none predicted", inst, inst_pc);
            end else begin
                mon_e = exp_q.pop_front();
                chk("sb inst",    inst,    mon_e.inst);
                chk("sb inst_pc", inst_pc, mon_e.pc);
                chk("sb pc4",     pc4,     mon_e.pc4);
            end
        end
    end

    initial begin
        rst_b          = 1'b1;
        redirect_valid = 1'b0;
        redirect_addr  = 32'h0;
        stall          = 1'b0;
        imem_ready     = 1'b0;
        #2;
        do_reset();

        // RESET_PC at the top of the address space wraps to 0
        chk("wrap req",  32'(w_req), 32'h1);
        chk("wrap addr", w_addr,     32'hFFFF_FFFC);
        step(0, 32'h0, 0, 1);
        chk("wrap valid",   32'(w_valid), 32'h1);
        chk("wrap inst",    w_inst,       mem_word(32'hFFFF_FFFC, halt_addr));
        chk("wrap inst_pc", w_inst_pc,    32'hFFFF_FFFC);
        chk("wrap pc4",     w_pc4,        32'h0);
        step(0, 32'h0, 0, 1);
        chk("wrap next valid", 32'(w_valid),  32'h0);
        chk("wrap next addr",  w_addr,        32'h0);
        chk("wrap halted",     32'(w_halted), 32'h0);

        // zero-wait streaming
        repeat (6) step(0, 32'h0, 0, 1);
        // ready delayed three cycles
        repeat (3) step(0, 32'h0, 0, 0);
        step(0, 32'h0, 0, 1);
        // held under stall, then released
        repeat (5) step(0, 32'h0, 1, 1);
        step(0, 32'h0, 0, 1);
        // redirect collides with ready, then squashes a stalled word
        step(1, 32'h0040_0103, 0, 1);
        step(0, 32'h0, 0, 1);
        step(1, 32'h0040_0103, 1, 0);
        step(0, 32'h0, 0, 1);
        step(0, 32'h0, 0, 0);
        // back-to-back redirects
        step(1, 32'h0000_0080, 0, 1);
        step(1, 32'h0000_0200, 0, 1);
        step(0, 32'h0, 0, 1);
        step(0, 32'h0, 0, 0);
        // pc wrap via redirect
        step(1, 32'hFFFF_FFFE, 0, 0);
        step(0, 32'h0, 0, 1);
        step(0, 32'h0, 0, 0);
        step(0, 32'h0, 0, 1);
        step(0, 32'h0, 0, 0);
        // reset while requesting
        step(0, 32'h0, 0, 0);
        do_reset();

        // halt at 0x10 parks the front end
        halt_addr = 32'h0000_0010;
        step(1, 32'h0000_0010, 0, 0);
        step(0, 32'h0, 0, 1);
        step(0, 32'h0, 0, 0);
        repeat (10) step(1'b1, $urandom, ($urandom % 2) == 1, 1'b1);
        repeat (10) rand_step();
        do_reset();
        // redirect in the consume cycle beats halt
        step(1, 32'h0000_0010, 0, 0);
        step(0, 32'h0, 0, 1);
        step(1, 32'h0000_0040, 0, 0);
        step(0, 32'h0, 0, 1);
        step(0, 32'h0, 0, 0);
        halt_addr = 32'h0000_0001;

        repeat (3000) rand_step();

        chk("scoreboard drained", 32'(exp_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
